// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_pkg
// Description : Shared constants and helpers for the fifo_sc_param FIFO family.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

  localparam int   DEFAULT_WIDTH = 8;
  localparam int   DEFAULT_DEPTH = 32768;
  localparam logic Q_RESET_BIT   = 1'b0;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_sc_param_if.sv
`default_nettype none
// ============================================================================
// Module      : fifo_sc_param_if
// Description : Write/read/status bundle between a FIFO user and fifo_sc_param.
// Revision    : 1.0 - initial release
// ============================================================================
interface fifo_sc_param_if
  import fifo_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
);
  localparam int CW = clog2(DEPTH) + 1;

  logic             sclr;
  logic [WIDTH-1:0] data;
  logic             wrreq;
  logic             rdreq;
  logic [WIDTH-1:0] q;
  logic             empty;
  logic             full;
  logic             almost_empty;
  logic             almost_full;
  logic [CW-1:0]    usedw;
  logic             overflow;
  logic             underflow;

  modport master (
    output sclr, data, wrreq, rdreq,
    input  q, empty, full, almost_empty, almost_full, usedw, overflow, underflow
  );

  modport slave (
    input  sclr, data, wrreq, rdreq,
    output q, empty, full, almost_empty, almost_full, usedw, overflow, underflow
  );

endinterface
`default_nettype wire

// File: rtl/fifo_sc_ram.sv
`default_nettype none
// ============================================================================
// Module      : fifo_sc_ram
// Description : Simple dual-port DEPTH x WIDTH RAM, registered read, no reset.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_sc_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clock,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem_q [0:DEPTH-1];
  logic [WIDTH-1:0] rd_data_q;

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Read register holds its value while rd_en is low; the FIFO relies on that.
  always_ff @(posedge clock) begin
    if (rd_en) begin
      rd_data_q <= mem_q[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule
`default_nettype wire

// File: rtl/fifo_sc_param.sv
`default_nettype none
// ============================================================================
// Module      : fifo_sc_param
// Description : Parametrised single-clock FIFO with exact fill count,
//               almost-full/empty thresholds and sticky error flags.
//               Define FIFO_SHOWAHEAD_EN for first-word-fall-through mode.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_sc_param
  import fifo_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int DEPTH    = DEFAULT_DEPTH,   // power of two, >= 4
  parameter int AF_LEVEL = DEPTH - 4,
  parameter int AE_LEVEL = 4
) (
  input  logic            clock,
  input  logic            rst_n,
  fifo_sc_param_if.slave  bus
);

  localparam int            AW        = clog2(DEPTH);
  localparam int            CW        = AW + 1;
  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_CNT    = CW'(AE_LEVEL);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    usedw_q, usedw_d;
  logic             empty_q, empty_d;
  logic             full_q, full_d;
  logic             almost_empty_q, almost_empty_d;
  logic             almost_full_q, almost_full_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             wr_ok;
  logic             rd_ok;
  logic             ram_rd_en;
  logic [WIDTH-1:0] ram_rd_data;

  fifo_sc_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clock   (clock),
    .wr_en   (wr_ok),
    .wr_addr (wr_ptr_q),
    .wr_data (bus.data),
    .rd_en   (ram_rd_en),
    .rd_addr (rd_ptr_q),
    .rd_data (ram_rd_data)
  );

`ifdef FIFO_SHOWAHEAD_EN
  // Prefetch pipeline: RAM read register (stage 1) feeds the output register.
  logic [CW-1:0]    ram_cnt_q, ram_cnt_d;
  logic             s1_valid_q, s1_valid_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             s1_move;

  always_comb begin
    wr_ok       = bus.wrreq & ~full_q & ~bus.sclr;
    rd_ok       = bus.rdreq & out_valid_q & ~bus.sclr;
    s1_move     = s1_valid_q & (~out_valid_q | rd_ok);
    ram_rd_en   = (ram_cnt_q != '0) & (~s1_valid_q | s1_move) & ~bus.sclr;
    rd_ptr_d    = ram_rd_en ? rd_ptr_q + AW'(1) : rd_ptr_q;
    s1_valid_d  = ram_rd_en | (s1_valid_q & ~s1_move);
    out_valid_d = s1_move | (out_valid_q & ~rd_ok);
    q_d         = s1_move ? ram_rd_data : q_q;
    unique case ({wr_ok, ram_rd_en})
      2'b10:   ram_cnt_d = ram_cnt_q + CW'(1);
      2'b01:   ram_cnt_d = ram_cnt_q - CW'(1);
      default: ram_cnt_d = ram_cnt_q;
    endcase
    if (bus.sclr) begin
      rd_ptr_d    = '0;
      s1_valid_d  = 1'b0;
      out_valid_d = 1'b0;
      q_d         = {WIDTH{Q_RESET_BIT}};
      ram_cnt_d   = '0;
    end
    empty_d = ~out_valid_d;
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      ram_cnt_q   <= '0;
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      q_q         <= {WIDTH{Q_RESET_BIT}};
    end else begin
      ram_cnt_q   <= ram_cnt_d;
      s1_valid_q  <= s1_valid_d;
      out_valid_q <= out_valid_d;
      q_q         <= q_d;
    end
  end

  assign bus.q = q_q;
`else
  // RAM read register is the output; q_live masks stale contents after reset/sclr.
  logic q_live_q, q_live_d;

  always_comb begin
    wr_ok     = bus.wrreq & ~full_q & ~bus.sclr;
    rd_ok     = bus.rdreq & ~empty_q & ~bus.sclr;
    ram_rd_en = rd_ok;
    rd_ptr_d  = rd_ok ? rd_ptr_q + AW'(1) : rd_ptr_q;
    q_live_d  = q_live_q | rd_ok;
    if (bus.sclr) begin
      rd_ptr_d = '0;
      q_live_d = 1'b0;
    end
    empty_d = (usedw_d == '0);
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      q_live_q <= 1'b0;
    end else begin
      q_live_q <= q_live_d;
    end
  end

  assign bus.q = q_live_q ? ram_rd_data : {WIDTH{Q_RESET_BIT}};
`endif

  always_comb begin
    wr_ptr_d = wr_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    unique case ({wr_ok, rd_ok})
      2'b10:   usedw_d = usedw_q + CW'(1);
      2'b01:   usedw_d = usedw_q - CW'(1);
      default: usedw_d = usedw_q;
    endcase
    overflow_d  = overflow_q | (bus.wrreq & full_q);
    underflow_d = underflow_q | (bus.rdreq & empty_q);
    if (bus.sclr) begin
      wr_ptr_d    = '0;
      usedw_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    // Flags follow the next-state count so they line up with usedw.
    full_d         = (usedw_d == DEPTH_CNT);
    almost_full_d  = (usedw_d >= AF_CNT);
    almost_empty_d = (usedw_d <= AE_CNT);
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      usedw_q        <= '0;
      empty_q        <= 1'b1;
      full_q         <= 1'b0;
      almost_empty_q <= 1'b1;
      almost_full_q  <= 1'b0;
      overflow_q     <= 1'b0;
      underflow_q    <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      usedw_q        <= usedw_d;
      empty_q        <= empty_d;
      full_q         <= full_d;
      almost_empty_q <= almost_empty_d;
      almost_full_q  <= almost_full_d;
      overflow_q     <= overflow_d;
      underflow_q    <= underflow_d;
    end
  end

  assign bus.usedw        = usedw_q;
  assign bus.empty        = empty_q;
  assign bus.full         = full_q;
  assign bus.almost_empty = almost_empty_q;
  assign bus.almost_full  = almost_full_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_sc_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_sc_param
// Description : Scoreboard bench for fifo_sc_param, WIDTH=8 DEPTH=16, normal mode.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_sc_param;

  logic clock;
  logic rst_n;

  fifo_sc_param_if #(.WIDTH(8), .DEPTH(16)) bus ();

  fifo_sc_param #(
    .WIDTH    (8),
    .DEPTH    (16),
    .AF_LEVEL (12),
    .AE_LEVEL (4)
  ) dut (
    .clock (clock),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] model [$];
  logic [7:0] exp_q [$];
  bit         m_ovf;
  bit         m_udf;
  logic [7:0] last_q;
  bit         rd_expect;
  logic [10:0] act_status;

  assign act_status = {bus.usedw, bus.empty, bus.full, bus.almost_empty,
                       bus.almost_full, bus.overflow, bus.underflow};

  initial begin
    clock = 1'b0;
    forever #10 clock = ~clock;
  end

  function automatic logic [10:0] exp_status();
    int n;
    n = model.size();
    return {5'(n), n == 0, n == 16, n <= 4, n >= 12, m_ovf, m_udf};
  endfunction

  task automatic check_status(input string name);
    logic [10:0] e;
    e = exp_status();
    n_checks++;
    if (act_status !== e) begin
      n_errors++;
      $display("FAIL %s: {usedw,empty,full,ae,af,ovf,udf} got %h required %h",
               name, act_status, e);
    end
  endtask

  task automatic check_q(input string name, input logic [7:0] e);
    n_checks++;
    if (bus.q !== e) begin
      n_errors++;
      $display("FAIL %s: q got %h required %h", name, bus.q, e);
    end
  endtask

  // Monitor: a read accepted at an edge must show its data on q right after it.
  always @(posedge clock) begin : monitor
    bit         take;
    logic [7:0] e;
    take = rd_expect;
    if (take) begin
      #2;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL read_data: q got %h required <no pending entry>", bus.q);
      end else begin
        e      = exp_q.pop_front();
        last_q = e;
        check_q("read_data", e);
      end
    end
  end

  // One clock of stimulus; starts just after an edge, returns 1 unit after the next.
  task automatic step(input bit wr, input logic [7:0] d, input bit rd, input string name);
    bit wr_acc;
    bit rd_acc;
    wr_acc = wr && (model.size() < 16);
    rd_acc = rd && (model.size() > 0);
    if (wr && !wr_acc) m_ovf = 1'b1;
    if (rd && !rd_acc) m_udf = 1'b1;
    if (rd_acc) exp_q.push_back(model.pop_front());
    if (wr_acc) model.push_back(d);
    bus.wrreq = wr;
    bus.data  = d;
    bus.rdreq = rd;
    rd_expect = rd_acc;
    @(posedge clock);
    #1;
    bus.wrreq = 1'b0;
    bus.rdreq = 1'b0;
    rd_expect = 1'b0;
    check_status(name);
  endtask

  task automatic model_clear();
    model.delete();
    exp_q.delete();
    m_ovf  = 1'b0;
    m_udf  = 1'b0;
    last_q = 8'h00;
  endtask

  task automatic do_sclr();
    bus.sclr = 1'b1;
    model_clear();
    @(posedge clock);
    #1;
    bus.sclr = 1'b0;
    check_status("sclr_status");
    check_q("sclr_q", 8'h00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: sim time got %0t required < 200000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    bus.sclr  = 1'b0;
    bus.wrreq = 1'b0;
    bus.rdreq = 1'b0;
    bus.data  = 8'h00;
    rd_expect = 1'b0;
    model_clear();
    repeat (2) @(posedge clock);
    #1;
    check_status("reset_status");
    check_q("reset_q", 8'h00);
    @(negedge clock);
    rst_n = 1'b1;
    @(posedge clock);
    #1;

    for (int i = 1; i <= 5; i++) step(1'b1, 8'(i), 1'b0, "write_5");
    for (int i = 0; i < 3; i++)  step(1'b0, 8'h00, 1'b1, "read_3");

    for (int i = 0; i < 14; i++) step(1'b1, 8'(8'h10 + i), 1'b0, "fill");
    step(1'b1, 8'hAA, 1'b0, "overflow_write");
    for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, "drain");
    step(1'b0, 8'h00, 1'b1, "underflow_read");
    check_q("underflow_q_hold", last_q);

    do_sclr();
    for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h20 + i), 1'b0, "fill_8");
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h30 + i), 1'b1, "simul_8");
    for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h40 + i), 1'b0, "fill_16");
    step(1'b1, 8'hBB, 1'b1, "simul_full");
    for (int i = 0; i < 15; i++) step(1'b0, 8'h00, 1'b1, "drain_15");
    step(1'b1, 8'hCC, 1'b1, "simul_empty");
    step(1'b0, 8'h00, 1'b1, "read_cc");

    for (int i = 1; i <= 3; i++) step(1'b1, 8'(8'h50 + i), 1'b0, "write_5x");
    do_sclr();
    step(1'b1, 8'h61, 1'b0, "write_61");
    step(1'b0, 8'h00, 1'b1, "read_61");

    for (int i = 0; i < 7; i++) step(1'b1, 8'(8'h70 + i), 1'b0, "fill_7");
    #4;
    rst_n = 1'b0;
    model_clear();
    #1;
    check_status("async_reset_status");
    check_q("async_reset_q", 8'h00);
    @(negedge clock);
    rst_n = 1'b1;
    @(posedge clock);
    #1;

    for (int i = 0; i < 3; i++)  step(1'b1, 8'(8'h80 + i), 1'b0, "wrap_prime");
    for (int i = 0; i < 40; i++) step(1'b1, 8'(8'h90 + i), 1'b1, "wrap_pair");
    for (int i = 0; i < 3; i++)  step(1'b0, 8'h00, 1'b1, "wrap_drain");

    repeat (2) @(posedge clock);
    #5;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_empty: pending got %0d required 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
